imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port, 1-cycle-latency synchronous instruction memory between the
//  core fetch port (read-only) and a loader/debug port (read/write, used for program load).
//  Sits between fetch stage, loader and the instruction BRAM.
//  Fixed loader priority, with a burst limit that guarantees fetch forward progress.
// PARAMETERS
//  ADDR_W     10  word-address width into memory (2**ADDR_W words, 1024 default)
//  BURST_MAX  4   max consecutive loader grants while fetch is waiting (>=1)
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       asynchronous, active-low reset (rst==0 resets)
//  f_req      in   1       fetch read request
//  f_addr     in   32      fetch byte address
//  f_gnt      out  1       fetch request accepted this cycle
//  f_rvalid   out  1       fetch read data valid
//  f_rdata    out  32      fetch read data
//  f_err      out  1       fetch response is misaligned-address error
//  l_req      in   1       loader request
//  l_we       in   1       loader write (1) / read (0)
//  l_addr     in   32      loader byte address
//  l_wdata    in   32      loader write data
//  l_gnt      out  1       loader request accepted this cycle
//  l_rvalid   out  1       loader read data valid
//  l_rdata    out  32      loader read data
//  mem_en     out  1       memory access enable
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory word address = addr[ADDR_W+1:2]
//  mem_wdata  out  32      memory write data
//  mem_rdata  in   32      memory read data, valid the cycle after mem_en & !mem_we
// BEHAVIOUR
//  - Grant is combinational in the request cycle; a request is accepted iff gnt=1.
//    Requesters hold req/addr/data until granted. At most one grant per cycle.
//  - FSM (registered): IDLE, FETCH, LOAD, FAIR. State = owner of the previous cycle.
//    IDLE: no grant. FETCH: f granted. LOAD: l granted. FAIR: forced f slot.
//  - burst_cnt (registered, 0..BURST_MAX): +1 per loader grant while f_req=1;
//    cleared on any fetch grant or any cycle with f_req=0.
//  - Arbitration: l_req & (burst_cnt<BURST_MAX or !f_req) -> grant l (LOAD);
//    else f_req -> grant f (FETCH, or FAIR if burst limit forced it); else IDLE.
//  - mem_en = f_gnt|l_gnt, except a misaligned fetch (f_addr[1:0]!=0): granted but
//    mem_en=0. mem_we = l_gnt & l_we. mem_wdata = l_wdata. mem_addr from the winner.
//    Loader addr[1:0] are ignored (word access).
//  - Read latency: exactly 1 cycle. A registered response tag steers mem_rdata:
//    f_rvalid/l_rvalid pulse 1 cycle after the granted read; the other is 0.
//    Loader writes produce no l_rvalid.
//  - Misaligned fetch: next cycle f_rvalid=1, f_err=1, f_rdata=0. f_err=0 otherwise.
//  - rdata outputs are 0 whenever their rvalid=0.
//  - Back-to-back grants allowed every cycle. Write-then-read of the same address by
//    the loader in consecutive cycles returns the new data (BRAM read-after-write).
//  - Reset: state=IDLE, burst_cnt=0, response tag cleared, all outputs 0. Reset
//    mid-operation drops any in-flight response; no rvalid after reset release
//    until a new read is granted.
// CONFIGURATION
//  IMEM_ARB_PERF_EN defined: adds outputs perf_fetch_cnt[31:0] (fetch grants) and
//    perf_stall_cnt[31:0] (cycles with f_req=1 & f_gnt=0). Both reset to 0 and wrap
//    at 2**32.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - Reset: rst=0 with random inputs -> all outputs 0; release; idle -> mem_en=0.
//  - Fetch: f_req, f_addr=0x8 -> f_gnt, mem_addr=2 same cycle; next cycle
//    f_rvalid=1, f_rdata=mem[2].
//  - Misaligned: f_addr=0x6 -> f_gnt=1, mem_en=0; next cycle f_rvalid=1, f_err=1,
//    f_rdata=0.
//  - Load then read: l_we=1, l_addr=0x10, l_wdata=0xDEADBEEF; then l_we=0 same addr
//    -> l_rvalid next cycle, l_rdata=0xDEADBEEF.
//  - Fairness: f_req and l_req held high, BURST_MAX=4 -> grant pattern L,L,L,L,F
//    repeating; f_rvalid only on the cycle after each F.
//  - Reset mid-read: grant fetch, assert rst=0 the next cycle -> no f_rvalid;
//    with IMEM_ARB_PERF_EN, counters read 0.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a 1-cycle synchronous instruction BRAM between fetch (read-only) and loader (rd/wr).
// Loader wins, but after BURST_MAX back-to-back grants fetch gets a slot; IMEM_ARB_PERF_EN adds perf counters.
module imem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int BURST_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              f_req_i,
    input  logic [31:0]       f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [31:0]       f_rdata_o,
    output logic              f_err_o,
    input  logic              l_req_i,
    input  logic              l_we_i,
    input  logic [31:0]       l_addr_i,
    input  logic [31:0]       l_wdata_i,
    output logic              l_gnt_o,
    output logic              l_rvalid_o,
    output logic [31:0]       l_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_LOAD, ST_FAIR} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          rsp_f_q, rsp_f_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_l_q, rsp_l_d;
    logic          f_gnt, l_gnt, f_mis;

    assign f_mis = (f_addr_i[1:0] != 2'b00);

    always_comb begin
        state_d   = ST_IDLE;
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        burst_d   = burst_q;
        if (l_req_i && ((burst_q < BW'(BURST_MAX)) || !f_req_i)) begin
            l_gnt   = 1'b1;
            state_d = ST_LOAD;
        end else if (f_req_i) begin
            f_gnt   = 1'b1;
            // A fetch grant with the loader still asking means the burst limit forced it.
            state_d = l_req_i ? ST_FAIR : ST_FETCH;
        end
        if (!f_req_i || f_gnt) begin
            burst_d = '0;
        end else if (l_gnt) begin
            burst_d = burst_q + BW'(1);
        end
        rsp_f_d   = f_gnt;
        rsp_err_d = f_gnt & f_mis;
        rsp_l_d   = l_gnt & ~l_we_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            burst_q   <= '0;
            rsp_f_q   <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_l_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            rsp_f_q   <= rsp_f_d;
            rsp_err_q <= rsp_err_d;
            rsp_l_q   <= rsp_l_d;
        end
    end

    // Request-side outputs are combinational, so hold them low while reset is asserted.
    assign f_gnt_o     = rst_ni & f_gnt;
    assign l_gnt_o     = rst_ni & l_gnt;
    assign mem_en_o    = rst_ni & (l_gnt | (f_gnt & ~f_mis));
    assign mem_we_o    = rst_ni & l_gnt & l_we_i;
    assign mem_wdata_o = rst_ni ? l_wdata_i : 32'h0;
    assign mem_addr_o  = !rst_ni ? '0 :
                         l_gnt   ? l_addr_i[ADDR_W+1:2] :
                         f_gnt   ? f_addr_i[ADDR_W+1:2] : '0;

    assign f_rvalid_o = rsp_f_q;
    assign f_err_o    = rsp_err_q;
    assign f_rdata_o  = (rsp_f_q && !rsp_err_q) ? mem_rdata_i : 32'h0;
    assign l_rvalid_o = rsp_l_q;
    assign l_rdata_o  = rsp_l_q ? mem_rdata_i : 32'h0;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            perf_fetch_q <= perf_fetch_q + {31'h0, f_gnt};
            perf_stall_q <= perf_stall_q + {31'h0, f_req_i & ~f_gnt};
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{f_addr_i[31:ADDR_W+2], l_addr_i[31:ADDR_W+2], l_addr_i[1:0], state_q};

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: attached BRAM, directed scenarios, then randomized traffic against a queue-free reference.
module tb_imem_arbiter;
    localparam int ADDR_W    = 10;
    localparam int BURST_MAX = 4;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              f_req, l_req, l_we;
    logic [31:0]       f_addr, l_addr, l_wdata;
    logic              f_gnt, f_rvalid, f_err, l_gnt, l_rvalid;
    logic [31:0]       f_rdata, l_rdata, mem_wdata, mem_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
`ifdef IMEM_ARB_PERF_EN
    logic [31:0]       perf_fetch_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    imem_arbiter #(.ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt),
        .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata), .f_err_o(f_err),
        .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_gnt_o(l_gnt), .l_rvalid_o(l_rvalid), .l_rdata_o(l_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef IMEM_ARB_PERF_EN
        , .perf_fetch_cnt_o(perf_fetch_cnt), .perf_stall_cnt_o(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int a);
        return (a * 32'h9E37_79B1) + 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench-side single-port BRAM, read-after-write across consecutive cycles.
    logic [31:0] bram [DEPTH];
    logic [31:0] bram_q;
    bit          bram_init = 1'b0;
    always @(posedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < DEPTH; i++) bram[i] = init_val(i);
            bram_init = 1'b1;
        end
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        bram_q <= bram[mem_addr];
        end
    end
    assign mem_rdata = bram_q;

    // Reference model: expected memory image, one pending response, loader streak length.
    logic [31:0] ref_mem [DEPTH];
    bit          ref_init = 1'b0;
    int          streak;
    bit          pend_f, pend_err, pend_l;
    logic [31:0] pend_data;
    logic [31:0] m_fetch, m_stall;
    bit          e_f, e_l, e_mis, e_en, e_we;
    int          fa, la;

    always @(negedge clk) begin
        if (!ref_init) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
            streak = 0; pend_f = 0; pend_err = 0; pend_l = 0; pend_data = 0;
            m_fetch = 0; m_stall = 0;
        end
        if (!rst_n) begin
            chk("rst_f_gnt", {31'h0, f_gnt}, 0);
            chk("rst_l_gnt", {31'h0, l_gnt}, 0);
            chk("rst_mem_en", {31'h0, mem_en}, 0);
            chk("rst_mem_we", {31'h0, mem_we}, 0);
            chk("rst_mem_addr", {22'h0, mem_addr}, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_f_rvalid", {31'h0, f_rvalid}, 0);
            chk("rst_f_err", {31'h0, f_err}, 0);
            chk("rst_f_rdata", f_rdata, 0);
            chk("rst_l_rvalid", {31'h0, l_rvalid}, 0);
            chk("rst_l_rdata", l_rdata, 0);
`ifdef IMEM_ARB_PERF_EN
            chk("rst_perf_fetch", perf_fetch_cnt, 0);
            chk("rst_perf_stall", perf_stall_cnt, 0);
`endif
            streak = 0; pend_f = 0; pend_err = 0; pend_l = 0; pend_data = 0;
            m_fetch = 0; m_stall = 0;
        end else begin
            e_l   = l_req && (!f_req || streak < BURST_MAX);
            e_f   = f_req && !e_l;
            e_mis = (f_addr % 4) != 0;
            e_en  = e_l || (e_f && !e_mis);
            e_we  = e_l && l_we;
            fa    = int'((f_addr / 4) % DEPTH);
            la    = int'((l_addr / 4) % DEPTH);
            chk("f_gnt", {31'h0, f_gnt}, {31'h0, e_f});
            chk("l_gnt", {31'h0, l_gnt}, {31'h0, e_l});
            chk("mem_en", {31'h0, mem_en}, {31'h0, e_en});
            chk("mem_we", {31'h0, mem_we}, {31'h0, e_we});
            if (e_en) chk("mem_addr", {22'h0, mem_addr}, e_l ? la : fa);
            if (e_we) chk("mem_wdata", mem_wdata, l_wdata);
            chk("f_rvalid", {31'h0, f_rvalid}, {31'h0, pend_f});
            chk("f_err", {31'h0, f_err}, {31'h0, pend_err});
            chk("f_rdata", f_rdata, (pend_f && !pend_err) ? pend_data : 32'h0);
            chk("l_rvalid", {31'h0, l_rvalid}, {31'h0, pend_l});
            chk("l_rdata", l_rdata, pend_l ? pend_data : 32'h0);
`ifdef IMEM_ARB_PERF_EN
            chk("perf_fetch", perf_fetch_cnt, m_fetch);
            chk("perf_stall", perf_stall_cnt, m_stall);
`endif
            pend_f    = e_f;
            pend_err  = e_f && e_mis;
            pend_l    = e_l && !l_we;
            pend_data = e_l ? ref_mem[la] : ref_mem[fa];
            if (e_we) ref_mem[la] = l_wdata;
            if (!f_req || e_f) streak = 0;
            else if (e_l)      streak = streak + 1;
            m_fetch = m_fetch + (e_f ? 1 : 0);
            m_stall = m_stall + ((f_req && !e_f) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    endtask

    string pat;

    initial begin
        rst_n = 1'b0;
        f_req = 1; f_addr = $urandom; l_req = 1; l_we = 1; l_addr = $urandom; l_wdata = $urandom;
        #2;
        chk("reset_f_gnt", {31'h0, f_gnt}, 0);
        chk("reset_mem_en", {31'h0, mem_en}, 0);
        step(); step();
        rst_n = 1'b1;
        idle_inputs();
        #2;
        chk("idle_mem_en", {31'h0, mem_en}, 0);
        step();

        // Aligned fetch of word 2.
        f_req = 1; f_addr = 32'h8;
        #2;
        chk("fetch_gnt", {31'h0, f_gnt}, 1);
        chk("fetch_mem_addr", {22'h0, mem_addr}, 2);
        step();
        idle_inputs();
        #2;
        chk("fetch_rvalid", {31'h0, f_rvalid}, 1);
        chk("fetch_rdata", f_rdata, init_val(2));
        step();

        // Misaligned fetch.
        f_req = 1; f_addr = 32'h6;
        #2;
        chk("mis_gnt", {31'h0, f_gnt}, 1);
        chk("mis_mem_en", {31'h0, mem_en}, 0);
        step();
        idle_inputs();
        #2;
        chk("mis_rvalid", {31'h0, f_rvalid}, 1);
        chk("mis_err", {31'h0, f_err}, 1);
        chk("mis_rdata", f_rdata, 0);
        step();

        // Loader write then read-back of the same word.
        l_req = 1; l_we = 1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF;
        #2;
        chk("ld_wr_gnt", {31'h0, l_gnt}, 1);
        chk("ld_wr_addr", {22'h0, mem_addr}, 4);
        step();
        l_we = 0;
        #2;
        chk("ld_wr_no_rvalid", {31'h0, l_rvalid}, 0);
        step();
        idle_inputs();
        #2;
        chk("ld_rd_rvalid", {31'h0, l_rvalid}, 1);
        chk("ld_rd_rdata", l_rdata, 32'hDEAD_BEEF);
        step();

        // Both requesters saturating: burst limit gives fetch every fifth slot.
        f_req = 1; f_addr = 32'h20; l_req = 1; l_we = 0; l_addr = 32'h30;
        pat = "";
        for (int i = 0; i < 10; i++) begin
            #2;
            pat = {pat, l_gnt ? "L" : (f_gnt ? "F" : "-")};
            step();
        end
        checks++;
        if (pat != "LLLLFLLLLF") begin
            errors++;
            $display("FAIL fair_pattern: got %s expected LLLLFLLLLF", pat);
        end
        idle_inputs();
        step();

        // Reset while a fetch response is in flight.
        f_req = 1; f_addr = 32'h8;
        #2;
        chk("rmid_gnt", {31'h0, f_gnt}, 1);
        step();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk("rmid_no_rvalid", {31'h0, f_rvalid}, 0);
`ifdef IMEM_ARB_PERF_EN
        chk("rmid_perf_fetch", perf_fetch_cnt, 0);
        chk("rmid_perf_stall", perf_stall_cnt, 0);
`endif
        step();
        rst_n = 1'b1;
        step();
        #2;
        chk("rmid_after_release", {31'h0, f_rvalid}, 0);
        step();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            rst_n   = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            f_req   = ($urandom_range(0, 3) != 0);
            f_addr  = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 31) << 2) |
                      (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            l_req   = ($urandom_range(0, 2) != 0);
            l_we    = $urandom_range(0, 1);
            l_addr  = ($urandom & 32'hFFFF_F000) | $urandom_range(0, 127);
            l_wdata = $urandom;
            step();
        end
        rst_n = 1'b1;
        idle_inputs();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
